// File: rtl/uart_rx_cfg_if.sv
// Received-word port of uart_rx_cfg: one held word plus its status flags.
// Handshake: rx_data_o and the three flags are stable while rx_valid_o is high; the word transfers on every clock where rx_valid_o && rx_ready_i, and overrun_o is a separate one-clock pulse outside the handshake.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic                 rx_ready_i;
  logic                 frame_err_o;
  logic                 parity_err_o;
  logic                 break_o;
  logic                 overrun_o;

  modport master (
    output rx_data_o, rx_valid_o, frame_err_o, parity_err_o, break_o, overrun_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o, rx_valid_o, frame_err_o, parity_err_o, break_o, overrun_o,
    output rx_ready_i
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// UART receiver: 16x oversampling, 3-sample majority vote, runtime divisor, one-word holding register.
// Optional parity bit is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int DIV_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] baud_div_i,
  output logic             busy_o,
  output logic [2:0]       state_dbg_o,
  uart_rx_cfg_if.master    rx_if
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t state_q, state_d;

  logic             rx_meta, rx_sync, rx_prev;
  logic [1:0]       arm_cnt;
  logic             start_edge;
  logic [DIV_W-1:0] div_q, tick_cnt;
  logic [3:0]       samp_cnt;
  logic             tick, mid_tick, end_tick;
  logic             s7, s8, maj;
  logic [3:0]       bit_cnt;
  logic             stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic             ferr_acc, stop_zero;
  logic             ferr_now, stop_zero_now, perr_now, brk_now;
  logic             frame_done;

  // arm_cnt keeps the reset value of the synchroniser from looking like a start edge
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      arm_cnt <= 2'd0;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  assign start_edge = (arm_cnt == 2'd3) && rx_prev && !rx_sync;

  assign tick     = (state_q != ST_IDLE) && (tick_cnt == div_q);
  assign mid_tick = tick && (samp_cnt == 4'd9);
  assign end_tick = tick && (samp_cnt == 4'd15);
  assign maj      = (s7 & s8) | (s7 & rx_sync) | (s8 & rx_sync);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      tick_cnt <= '0;
      samp_cnt <= '0;
      s7       <= 1'b1;
      s8       <= 1'b1;
    end else begin
      if (state_q == ST_IDLE) begin
        tick_cnt <= '0;
        samp_cnt <= '0;
        if (start_edge) div_q <= (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
      end else if (tick) begin
        tick_cnt <= '0;
        samp_cnt <= samp_cnt + 4'd1;
        if (samp_cnt == 4'd7) s7 <= rx_sync;
        if (samp_cnt == 4'd8) s8 <= rx_sync;
      end else begin
        tick_cnt <= tick_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_edge) state_d = ST_START;
      ST_START: begin
        if (mid_tick && maj)  state_d = ST_IDLE;
        else if (end_tick)    state_d = ST_DATA;
      end
      ST_DATA: begin
        if (end_tick && (bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (end_tick) state_d = ST_STOP;
`endif
      ST_STOP: begin
        // finishing at mid-bit leaves half a stop bit to catch the next start edge
        if (mid_tick && (stop_cnt == LAST_STOP)) begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                                   par_bit <= 1'b0;
    else if ((state_q == ST_PARITY) && mid_tick)  par_bit <= maj;
  end

  assign perr_now = par_bit != ((^shreg) ^ 1'(PARITY_ODD));
  assign brk_now  = (shreg == '0) && !par_bit && stop_zero_now;
`else
  assign perr_now = 1'b0;
  assign brk_now  = (shreg == '0) && stop_zero_now;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shreg     <= '0;
      ferr_acc  <= 1'b0;
      stop_zero <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt   <= '0;
          stop_cnt  <= 1'b0;
          ferr_acc  <= 1'b0;
          stop_zero <= 1'b1;
        end
        ST_DATA: begin
          if (mid_tick) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (end_tick) bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
        end
        ST_STOP: begin
          if (mid_tick) begin
            if (!maj) ferr_acc  <= 1'b1;
            else      stop_zero <= 1'b0;
          end
          if (end_tick) stop_cnt <= stop_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // the stop bit judged in the completing clock is folded in combinationally
  assign ferr_now      = ferr_acc | !maj;
  assign stop_zero_now = stop_zero & !maj;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rx_if.rx_data_o    <= '0;
      rx_if.rx_valid_o   <= 1'b0;
      rx_if.frame_err_o  <= 1'b0;
      rx_if.parity_err_o <= 1'b0;
      rx_if.break_o      <= 1'b0;
      rx_if.overrun_o    <= 1'b0;
    end else begin
      rx_if.overrun_o <= 1'b0;
      if (frame_done) begin
        if (rx_if.rx_valid_o && !rx_if.rx_ready_i) begin
          rx_if.overrun_o <= 1'b1;
        end else begin
          rx_if.rx_data_o    <= shreg;
          rx_if.frame_err_o  <= ferr_now;
          rx_if.parity_err_o <= perr_now;
          rx_if.break_o      <= brk_now;
          rx_if.rx_valid_o   <= 1'b1;
        end
      end else if (rx_if.rx_valid_o && rx_if.rx_ready_i) begin
        rx_if.rx_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign state_dbg_o = state_q;

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver with 16x oversampling, majority-vote bit sampling, runtime baud divisor, configurable frame format and a one-word output holding register with valid/ready handshake. It sits between the board RX pin and the command parser / FIFO in the platform fabric. It also reports framing, parity, break and overrun status per received word.

## Interface
- DATA_BITS, 8, payload bits per frame; legal 5..9.
- STOP_BITS, 1, stop bits checked; legal 1 or 2.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; used only when parity is compiled in.
- DIV_W, 16, width of baud divisor.
- clk_i  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- rx_i  input  1  serial line, idle high, asynchronous to clk_i.
- baud_div_i  input  DIV_W  oversample tick period minus 1; tick every baud_div_i+1 clocks.
- rx_ready_i  input  1  consumer accepts the held word.
- rx_data_o  output  DATA_BITS  received word, LSB = first bit on the line.
- rx_valid_o  output  1  held word valid.
- frame_err_o  output  1  stop-bit error on the held word.
- parity_err_o  output  1  parity error on the held word.
- break_o  output  1  held word is a break (all data 0, parity 0 if present, stop 0).
- overrun_o  output  1  one-clock pulse: a completed frame was discarded.
- busy_o  output  1  high in any state other than IDLE.

## Operation
- rx_i passes through a 2-FF synchroniser reset to 1. Start detection uses the falling edge of the synchronised line.
- The divisor is latched at the start edge; changes mid-frame are ignored. A latched value of 0 is treated as 1.
- The tick counter restarts on the start edge and runs only outside IDLE. A sample counter runs 0..15 per bit.
- Bit value = majority of the synchronised line at ticks 7, 8 and 9 of the bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on falling edge.
  - START: at tick 9, a majority of 1 means a false start -> IDLE with no flags and no valid; otherwise -> DATA after tick 15.
  - DATA: shifts DATA_BITS bits LSB first. After the last bit -> PARITY if compiled in, else STOP.
  - PARITY: computes the expected parity, then -> STOP.
  - STOP: checks STOP_BITS stop bits. A majority of 0 in any stop bit sets frame error. At tick 9 of the last stop bit -> IDLE and the frame completes. This leaves half a bit of slack so back-to-back frames are not missed.
- On frame completion:
  - If rx_valid_o=1 and rx_ready_i=0: pulse overrun_o and keep the held word and its flags unchanged.
  - Otherwise load rx_data_o and the flags, and set rx_valid_o=1.
- rx_valid_o clears on the clock where rx_valid_o and rx_ready_i are both high. If a frame completes in that same clock, the new word loads, rx_valid_o stays 1 and overrun_o stays 0.
- break_o implies frame_err_o=1.

## Timing
- Reset values: rx_data_o=0, rx_valid_o=0, frame_err_o=0, parity_err_o=0, break_o=0, overrun_o=0, busy_o=0, FSM=IDLE.
- Bit period = 16*(baud_div_i+1) clocks.
- Latency:
  - rx_i to synchronised edge: 2 clocks.
  - rx_valid_o and flags register 1 clock after the clock that processes tick 9 of the last stop bit.
  - overrun_o pulses in that same clock, for exactly 1 clock.
- busy_o asserts 1 clock after the start edge is seen and deasserts with the return to IDLE.
- rst_n asserted mid-frame: all state and outputs return to reset values immediately and the partial frame is lost. After release, the block waits for a fresh falling edge; a line held low at release is not taken as a start.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state exists and one parity bit is expected after the data bits. parity_err_o is set when the received bit differs from the expected even/odd parity of the data.
- UART_RX_PARITY_EN undefined: there is no PARITY state and no parity bit in the frame. parity_err_o is tied to 0 and PARITY_ODD is ignored.

## Test plan
- Clean word: baud_div_i=26, 8N1 frame carrying 0xA5 -> rx_valid_o=1, rx_data_o=0xA5, all error flags 0. Ready pulse -> valid drops the next clock.
- Glitch: line low for 4 ticks, then high -> no rx_valid_o, busy_o returns to 0, no flags.
- Framing: 0x3C sent with stop bit 0 -> rx_data_o=0x3C, frame_err_o=1, break_o=0.
- Break: line low for 2 frame times -> rx_data_o=0x00, frame_err_o=1, break_o=1. The next clean 0x55 after the line returns high -> 0x55 with no flags.
- Overrun: 0x11 then 0x22 back-to-back with rx_ready_i=0 -> rx_data_o stays 0x11, overrun_o pulses once. Ready given in the completion clock of 0x22 instead -> 0x22 loads and overrun_o=0.
- Parity (macro defined, PARITY_ODD=0): 0x07 with parity bit 0 -> parity_err_o=1. With parity bit 1 -> parity_err_o=0.
